// File: rtl/mop_sequencer_pkg.sv
// Shared decoder types, register map and crack-class helpers for the micro-op sequencer.
package mop_sequencer_pkg;

    typedef enum logic [4:0] {
        rax    = 5'd0,
        rcx    = 5'd1,
        rdx    = 5'd2,
        rbx    = 5'd3,
        rsp    = 5'd4,
        rbp    = 5'd5,
        rsi    = 5'd6,
        rdi    = 5'd7,
        rflags = 5'd16,
        rtmp0  = 5'd17,
        rtmp1  = 5'd18,
        rnil   = 5'd31
    } reg_id_t;

    typedef enum logic [7:0] {
        m_nop     = 8'h00,
        m_add     = 8'h01,
        m_sub     = 8'h02,
        m_and     = 8'h03,
        m_or      = 8'h04,
        m_xor     = 8'h05,
        m_jcc     = 8'h20,
        m_lea     = 8'h40,
        m_ld      = 8'h41,
        m_st      = 8'h42,
        m_syscall = 8'h50
    } micro_opcode_t;

    typedef enum logic [3:0] {
        CLS_RR   = 4'd0,
        CLS_LDOP = 4'd1,
        CLS_RMW  = 4'd2,
        CLS_JCC  = 4'd3,
        CLS_SYS  = 4'd4
    } crack_class_t;

    localparam int ALU_OP_LSB = 0;
    localparam int ALU_OP_MSB = 7;
    localparam int CLASS_LSB  = 8;
    localparam int CLASS_MSB  = 11;

    typedef struct packed {
        logic [15:0] group;
    } opcode_struct_t;

    typedef struct packed {
        reg_id_t base;
        reg_id_t index;
    } operand_t;

    typedef struct packed {
        opcode_struct_t opcode_struct;
        operand_t       op0;
        operand_t       op1;
        logic [1:0]     scale;
        logic [31:0]    disp;
        logic [31:0]    immediate;
        logic [31:0]    rip_val;
    } fat_instruction_t;

    typedef struct packed {
        micro_opcode_t uopcode;
        reg_id_t       src0;
        reg_id_t       src1;
        reg_id_t       dst;
        logic [31:0]   src0_val;
        logic [31:0]   src1_val;
        logic [31:0]   dst_val;
        logic [1:0]    scale;
        logic [31:0]   disp;
        logic [31:0]   immediate;
        logic [31:0]   rip_val;
    } micro_op_t;

    // Zero marks an undefined crack class.
    function automatic logic [2:0] uop_count(logic [3:0] cls);
        case (cls)
            CLS_RR, CLS_JCC, CLS_SYS: return 3'd1;
            CLS_LDOP:                 return 3'd3;
            CLS_RMW:                  return 3'd4;
            default:                  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mop_crack_rom.sv
// Combinational crack table: (instruction, micro-op index) -> micro-op.
module mop_crack_rom
    import mop_sequencer_pkg::*;
#(
    parameter int SEQ_W = 2
)(
    input  logic [$bits(fat_instruction_t)-1:0] inst,
    input  logic [SEQ_W-1:0]                    idx,
    output logic [$bits(micro_op_t)-1:0]        uop
);

    fat_instruction_t fi;
    micro_opcode_t    alu_op;
    logic [3:0]       cls;
    micro_op_t        mo;

    assign fi     = fat_instruction_t'(inst);
    assign alu_op = micro_opcode_t'(fi.opcode_struct.group[ALU_OP_MSB:ALU_OP_LSB]);
    assign cls    = fi.opcode_struct.group[CLASS_MSB:CLASS_LSB];

    // NOTE: every field gets a default before the case, so no path leaves mo unassigned and no latch is inferred.
    always_comb begin
        mo           = '0;
        mo.uopcode   = m_nop;
        mo.src0      = rnil;
        mo.src1      = rnil;
        mo.dst       = rnil;
        mo.scale     = fi.scale;
        mo.disp      = fi.disp;
        mo.immediate = fi.immediate;
        mo.rip_val   = fi.rip_val;
        case (cls)
            CLS_RR: begin
                mo.uopcode = alu_op;  mo.src0 = fi.op0.base;  mo.src1 = fi.op1.base;  mo.dst = fi.op0.base;
            end
            CLS_LDOP: begin
                case (int'(idx))
                    0:       begin mo.uopcode = m_lea;  mo.src0 = fi.op1.base;  mo.src1 = fi.op1.index;  mo.dst = rtmp0; end
                    1:       begin mo.uopcode = m_ld;   mo.src0 = rtmp0;        mo.src1 = rnil;          mo.dst = rtmp1; end
                    default: begin mo.uopcode = alu_op; mo.src0 = fi.op0.base;  mo.src1 = rtmp1;         mo.dst = fi.op0.base; end
                endcase
            end
            CLS_RMW: begin
                case (int'(idx))
                    0:       begin mo.uopcode = m_lea;  mo.src0 = fi.op0.base;  mo.src1 = fi.op0.index;  mo.dst = rtmp0; end
                    1:       begin mo.uopcode = m_ld;   mo.src0 = rtmp0;        mo.src1 = rnil;          mo.dst = rtmp1; end
                    2:       begin mo.uopcode = alu_op; mo.src0 = rtmp1;        mo.src1 = fi.op1.base;   mo.dst = rtmp1; end
                    default: begin mo.uopcode = m_st;   mo.src0 = rtmp1;        mo.src1 = rtmp0;         mo.dst = rnil; end
                endcase
            end
            // Jump target is formed downstream from immediate + rip_val.
            CLS_JCC: begin
                mo.uopcode = alu_op;  mo.src1 = rflags;
            end
            CLS_SYS: begin
                mo.uopcode = m_syscall;
            end
            default: ;
        endcase
    end

    assign uop = mo;

endmodule

// File: rtl/mop_sequencer.sv
// Cracks one decoded instruction per handshake into 1-4 micro-ops on a registered valid/ready output.
module mop_sequencer
    import mop_sequencer_pkg::*;
#(
    parameter int MAX_UOPS = 4
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                inst_valid,
    output logic                                inst_ready,
    input  logic [$bits(fat_instruction_t)-1:0] inst,
    output logic                                mop_valid,
    input  logic                                mop_ready,
    output logic [$bits(micro_op_t)-1:0]        mop,
    output logic [$clog2(MAX_UOPS)-1:0]         mop_seq,
    output logic                                mop_last,
    output logic                                bad_class
);

    localparam int SEQ_W = $clog2(MAX_UOPS);
    localparam int CNT_W = SEQ_W + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                              state;
    fat_instruction_t                    inst_s;
    logic [$bits(fat_instruction_t)-1:0] inst_q;
    logic [CNT_W-1:0]                    count_q;
    logic [CNT_W-1:0]                    inst_count;
    logic [SEQ_W-1:0]                    next_idx;
    logic [SEQ_W-1:0]                    rom_idx;
    logic [$bits(fat_instruction_t)-1:0] rom_inst;
    logic [$bits(micro_op_t)-1:0]        rom_uop;
    logic                                inst_fire;

    assign inst_s     = fat_instruction_t'(inst);
    assign inst_count = CNT_W'(uop_count(inst_s.opcode_struct.group[CLASS_MSB:CLASS_LSB]));

    // A new instruction is taken only when idle or when the final uop leaves this very cycle.
    assign inst_ready = !reset && !flush && (state == IDLE || (mop_valid && mop_last && mop_ready));
    assign inst_fire  = inst_valid && inst_ready;
    assign next_idx   = mop_seq + SEQ_W'(1);

    // One ROM serves both the accept edge (uop 0 of the incoming inst) and in-flight advance.
    assign rom_inst = inst_fire ? inst : inst_q;
    assign rom_idx  = inst_fire ? '0 : next_idx;

    mop_crack_rom #(.SEQ_W(SEQ_W)) u_crack_rom (
        .inst (rom_inst),
        .idx  (rom_idx),
        .uop  (rom_uop)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mop_valid <= 1'b0;
            mop       <= '0;
            mop_seq   <= '0;
            mop_last  <= 1'b0;
            bad_class <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            mop_valid <= 1'b0;
            mop_seq   <= '0;
            mop_last  <= 1'b0;
            bad_class <= 1'b0;
        end else begin
            bad_class <= 1'b0;
            if (inst_fire) begin
                if (inst_count == '0) begin
                    bad_class <= 1'b1;
                    state     <= IDLE;
                    mop_valid <= 1'b0;
                    mop_seq   <= '0;
                    mop_last  <= 1'b0;
                end else begin
                    state     <= EMIT;
                    mop_valid <= 1'b1;
                    mop       <= rom_uop;
                    mop_seq   <= '0;
                    mop_last  <= (inst_count == CNT_W'(1));
                end
            end else if (state == EMIT && mop_ready) begin
                if (mop_last) begin
                    state     <= IDLE;
                    mop_valid <= 1'b0;
                    mop_seq   <= '0;
                    mop_last  <= 1'b0;
                end else begin
                    mop      <= rom_uop;
                    mop_seq  <= next_idx;
                    mop_last <= ({1'b0, next_idx} == count_q - CNT_W'(1));
                end
            end
        end
    end

    // NOTE: the latched instruction is pure datapath; it is only read after a fresh accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (inst_fire) begin
            inst_q  <= inst;
            count_q <= inst_count;
        end
    end

endmodule

// File: tb/tb_mop_sequencer.sv
// Self-checking bench: queue-based expected-uop model plus directed literal checks.
module tb_mop_sequencer;
    import mop_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             reset, flush, inst_valid, mop_ready;
    logic             inst_ready, mop_valid, mop_last, bad_class;
    logic [1:0]       mop_seq;
    fat_instruction_t inst_s;
    micro_op_t        mop_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        micro_op_t  uop;
        logic [1:0] seq;
        logic       last;
    } exp_t;

    typedef struct {
        micro_opcode_t op;
        logic [1:0]    seq;
        logic [31:0]   disp;
        int            cyc;
    } seen_t;

    exp_t  q[$];
    seen_t seen[$];
    logic  exp_bad = 1'b0;

    mop_sequencer #(.MAX_UOPS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst_s),
        .mop_valid  (mop_valid),
        .mop_ready  (mop_ready),
        .mop        (mop_s),
        .mop_seq    (mop_seq),
        .mop_last   (mop_last),
        .bad_class  (bad_class)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ex(fat_instruction_t i, micro_opcode_t op, reg_id_t s0, reg_id_t s1,
                                reg_id_t d, logic [1:0] seq, logic last);
        exp_t e;
        e.uop           = '0;
        e.uop.uopcode   = op;
        e.uop.src0      = s0;
        e.uop.src1      = s1;
        e.uop.dst       = d;
        e.uop.scale     = i.scale;
        e.uop.disp      = i.disp;
        e.uop.immediate = i.immediate;
        e.uop.rip_val   = i.rip_val;
        e.seq           = seq;
        e.last          = last;
        return e;
    endfunction

    // Expected micro-op list per crack class, straight from the class table.
    function automatic void push_uops(fat_instruction_t i);
        micro_opcode_t op;
        op = micro_opcode_t'(i.opcode_struct.group[7:0]);
        case (i.opcode_struct.group[11:8])
            4'd0: q.push_back(ex(i, op, i.op0.base, i.op1.base, i.op0.base, 2'd0, 1'b1));
            4'd1: begin
                q.push_back(ex(i, m_lea, i.op1.base, i.op1.index, rtmp0, 2'd0, 1'b0));
                q.push_back(ex(i, m_ld, rtmp0, rnil, rtmp1, 2'd1, 1'b0));
                q.push_back(ex(i, op, i.op0.base, rtmp1, i.op0.base, 2'd2, 1'b1));
            end
            4'd2: begin
                q.push_back(ex(i, m_lea, i.op0.base, i.op0.index, rtmp0, 2'd0, 1'b0));
                q.push_back(ex(i, m_ld, rtmp0, rnil, rtmp1, 2'd1, 1'b0));
                q.push_back(ex(i, op, rtmp1, i.op1.base, rtmp1, 2'd2, 1'b0));
                q.push_back(ex(i, m_st, rtmp1, rtmp0, rnil, 2'd3, 1'b1));
            end
            4'd3: q.push_back(ex(i, op, rnil, rflags, rnil, 2'd0, 1'b1));
            4'd4: q.push_back(ex(i, m_syscall, rnil, rnil, rnil, 2'd0, 1'b1));
            default: ;
        endcase
    endfunction

    // Compare outputs against the model, then advance the model across the coming edge.
    always @(negedge clk) begin : compare
        logic exp_rdy;
        check("mop_valid", 256'(mop_valid), 256'(q.size() != 0));
        if (q.size() != 0) begin
            check("mop", 256'(mop_s), 256'(q[0].uop));
            check("mop_seq", 256'(mop_seq), 256'(q[0].seq));
            check("mop_last", 256'(mop_last), 256'(q[0].last));
        end
        check("bad_class", 256'(bad_class), 256'(exp_bad));
        if (reset || flush) begin
            if (!reset) check("inst_ready_flush", 256'(inst_ready), 256'(0));
            q.delete();
            exp_bad = 1'b0;
        end else begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && mop_ready);
            check("inst_ready", 256'(inst_ready), 256'(exp_rdy));
            exp_bad = 1'b0;
            if (q.size() != 0 && mop_ready) void'(q.pop_front());
            if (inst_valid && exp_rdy) begin
                if (inst_s.opcode_struct.group[11:8] > 4'd4) exp_bad = 1'b1;
                else push_uops(inst_s);
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (!reset && mop_valid && mop_ready)
            seen.push_back('{op: mop_s.uopcode, seq: mop_seq, disp: mop_s.disp, cyc: cyc});
    end

    function automatic fat_instruction_t mk(logic [3:0] cls, micro_opcode_t op, reg_id_t b0, reg_id_t i0,
                                            reg_id_t b1, reg_id_t i1, logic [31:0] disp);
        fat_instruction_t i;
        i                     = '0;
        i.opcode_struct.group = {4'h0, cls, op};
        i.op0.base            = b0;
        i.op0.index           = i0;
        i.op1.base            = b1;
        i.op1.index           = i1;
        i.scale               = 2'd2;
        i.disp                = disp;
        i.immediate           = 32'hA5A5_0000 + disp;
        i.rip_val             = 32'h0040_1000 + disp;
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input fat_instruction_t i);
        int n = 0;
        inst_s     = i;
        inst_valid = 1'b1;
        @(negedge clk);
        while (!inst_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", 256'(inst_ready), 256'(1));
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (mop_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 256'(mop_valid), 256'(0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        micro_opcode_t rmw_ops[4];
        rmw_ops = '{m_lea, m_ld, m_add, m_st};
        reset = 1'b1; flush = 1'b0; inst_valid = 1'b0; mop_ready = 1'b1; inst_s = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_mop_valid", 256'(mop_valid), 256'(0));
        check("rst_mop", 256'(mop_s), 256'(0));
        check("rst_mop_seq", 256'(mop_seq), 256'(0));
        check("rst_mop_last", 256'(mop_last), 256'(0));
        check("rst_bad_class", 256'(bad_class), 256'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 256'(inst_ready), 256'(1));
        tick();

        // Register-register: single uop one cycle after accept.
        send(mk(CLS_RR, m_add, rax, rnil, rbx, rnil, 32'h0));
        @(negedge clk);
        check("rr_op", 256'(mop_s.uopcode), 256'(m_add));
        check("rr_src0", 256'(mop_s.src0), 256'(rax));
        check("rr_src1", 256'(mop_s.src1), 256'(rbx));
        check("rr_dst", 256'(mop_s.dst), 256'(rax));
        check("rr_seq", 256'(mop_seq), 256'(0));
        check("rr_last", 256'(mop_last), 256'(1));
        check("rr_ready", 256'(inst_ready), 256'(1));
        tick();
        wait_idle();

        // Read-modify-write on [rsi+rdi*4].
        seen.delete();
        send(mk(CLS_RMW, m_add, rsi, rdi, rcx, rnil, 32'h10));
        wait_idle();
        check("rmw_count", 256'(seen.size()), 256'(4));
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            check("rmw_op", 256'(seen[k].op), 256'(rmw_ops[k]));
            check("rmw_seq", 256'(seen[k].seq), 256'(k));
            check("rmw_disp", 256'(seen[k].disp), 256'(32'h10));
            check("rmw_gap", 256'(seen[k].cyc - seen[0].cyc), 256'(k));
        end

        // Backpressure on the load uop of a load-op.
        seen.delete();
        send(mk(CLS_LDOP, m_sub, rdx, rnil, rbp, rsi, 32'h8));
        tick();
        mop_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_op", 256'(mop_s.uopcode), 256'(m_ld));
            check("bp_hold_seq", 256'(mop_seq), 256'(1));
            tick();
        end
        mop_ready = 1'b1;
        wait_idle();
        check("bp_count", 256'(seen.size()), 256'(3));
        if (seen.size() == 3) begin
            check("bp_op0", 256'(seen[0].op), 256'(m_lea));
            check("bp_op1", 256'(seen[1].op), 256'(m_ld));
            check("bp_op2", 256'(seen[2].op), 256'(m_sub));
        end

        // Back-to-back single-uop stream.
        seen.delete();
        for (int k = 0; k < 5; k++)
            send(mk(CLS_RR, m_xor, reg_id_t'(k), rnil, rdi, rnil, 32'(k)));
        wait_idle();
        check("b2b_count", 256'(seen.size()), 256'(5));
        for (int k = 0; k < 5 && k < seen.size(); k++) begin
            check("b2b_disp", 256'(seen[k].disp), 256'(k));
            check("b2b_gap", 256'(seen[k].cyc - seen[0].cyc), 256'(k));
        end

        // Flush while seq 1 of an RMW is presented; an inst offered during flush is refused.
        seen.delete();
        send(mk(CLS_RMW, m_or, rbx, rsi, rdx, rnil, 32'h20));
        tick();
        flush = 1'b1;
        inst_s = mk(CLS_RR, m_and, rcx, rnil, rdx, rnil, 32'h30);
        inst_valid = 1'b1;
        @(negedge clk);
        check("flush_at_seq", 256'(mop_seq), 256'(1));
        check("flush_no_ready", 256'(inst_ready), 256'(0));
        tick();
        flush = 1'b0;
        inst_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 256'(mop_valid), 256'(0));
        tick();
        tick();
        check("flush_count", 256'(seen.size()), 256'(2));
        send(mk(CLS_RR, m_and, rcx, rnil, rdx, rnil, 32'h30));
        @(negedge clk);
        check("post_flush_seq", 256'(mop_seq), 256'(0));
        check("post_flush_op", 256'(mop_s.uopcode), 256'(m_and));
        tick();
        wait_idle();

        // Undefined class: one-cycle pulse, nothing emitted, next inst is normal.
        seen.delete();
        send(mk(4'hF, m_add, rax, rnil, rbx, rnil, 32'h40));
        @(negedge clk);
        check("bad_pulse", 256'(bad_class), 256'(1));
        check("bad_no_uop", 256'(mop_valid), 256'(0));
        tick();
        @(negedge clk);
        check("bad_one_cycle", 256'(bad_class), 256'(0));
        tick();
        send(mk(CLS_SYS, m_nop, rnil, rnil, rnil, rnil, 32'h44));
        wait_idle();
        check("bad_next_count", 256'(seen.size()), 256'(1));
        if (seen.size() == 1) check("bad_next_op", 256'(seen[0].op), 256'(m_syscall));

        // Jump class and reset in the middle of an RMW.
        send(mk(CLS_JCC, m_jcc, rnil, rnil, rnil, rnil, 32'h80));
        wait_idle();
        send(mk(CLS_RMW, m_sub, rdi, rsi, rax, rnil, 32'h50));
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_valid", 256'(mop_valid), 256'(0));
        check("mid_rst_mop", 256'(mop_s), 256'(0));
        check("mid_rst_seq", 256'(mop_seq), 256'(0));
        check("mid_rst_last", 256'(mop_last), 256'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 256'(inst_ready), 256'(1));
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
